// File: rtl/trap_seq_if.sv
// Trap channel between the trap sequencer (master) and the CSR register file (slave).
// Read data is combinational and valid in the same cycle as the address.
interface trap_seq_if;
    logic        trap_csr_we;
    logic [11:0] trap_csr_addr;
    logic [31:0] trap_csr_wdata;
    logic [31:0] trap_csr_rdata;

    modport master (
        output trap_csr_we,
        output trap_csr_addr,
        output trap_csr_wdata,
        input  trap_csr_rdata
    );

    modport slave (
        input  trap_csr_we,
        input  trap_csr_addr,
        input  trap_csr_wdata,
        output trap_csr_rdata
    );
endinterface

// File: rtl/trap_seq.sv
// Trap/mret sequencer: accepts exceptions, interrupts and mret at an instruction boundary,
// updates the machine trap CSRs over the trap channel and redirects fetch with one jump.
module trap_seq #(
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [11:0] CSR_MSTATUS_A = 12'h300,
    parameter logic [11:0] CSR_MTVEC_A   = 12'h305,
    parameter logic [11:0] CSR_MEPC_A    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE_A  = 12'h342,
    parameter logic [11:0] CSR_MTVAL_A   = 12'h343
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        ex_trap_valid_i,
    input  logic        soft_trap_valid_i,
    input  logic        tcmp_trap_valid_i,
    input  logic        mstatus_MIE3_i,
    trap_seq_if.master  csr_bus,
    output logic        hold_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_TVAL,
        S_STAT,
        S_JUMP
    } state_t;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
    localparam logic [31:0] CAUSE_SW_IRQ  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TMR_IRQ = 32'h8000_0007;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic        is_mret_q, is_mret_d;

    logic        evt_hit;
    logic        evt_mret;
    logic [31:0] evt_cause;
    logic [31:0] evt_tval;
    logic        accept;

    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] tvec_base;
    logic        vec_mode;

    // Trap entry: MPIE <= MIE, MIE <= 0.
    function automatic logic [31:0] trap_status(input logic [31:0] st);
        return {24'h0, st[3], 3'h0, 1'b0, 3'h0};
    endfunction

    // mret: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] mret_status(input logic [31:0] st);
        return {24'h0, 1'b1, 3'h0, st[7], 3'h0};
    endfunction

    assign csr_rdata = csr_bus.trap_csr_rdata;

    // Priority: exceptions, then mret, then interrupts (only with global enable).
    always_comb begin
        evt_hit   = 1'b1;
        evt_mret  = 1'b0;
        evt_cause = 32'h0;
        evt_tval  = 32'h0;
        if (illegal_i) begin
            evt_cause = CAUSE_ILLEGAL;
            evt_tval  = inst_i;
        end else if (ebreak_i) begin
            evt_cause = CAUSE_EBREAK;
            evt_tval  = inst_addr_i;
        end else if (ecall_i) begin
            evt_cause = CAUSE_ECALL;
        end else if (mret_i) begin
            evt_mret  = 1'b1;
        end else if (mstatus_MIE3_i && ex_trap_valid_i) begin
            evt_cause = CAUSE_EXT_IRQ;
        end else if (mstatus_MIE3_i && soft_trap_valid_i) begin
            evt_cause = CAUSE_SW_IRQ;
        end else if (mstatus_MIE3_i && tcmp_trap_valid_i) begin
            evt_cause = CAUSE_TMR_IRQ;
        end else begin
            evt_hit   = 1'b0;
        end
    end

    // Gated by rst_n so hold_o is low for the whole reset, not just after the first edge.
    assign accept = rst_n && (state_q == S_IDLE) && inst_valid_i && evt_hit;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        is_mret_d = is_mret_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pc_d      = inst_addr_i;
                    cause_d   = evt_cause;
                    tval_d    = evt_tval;
                    is_mret_d = evt_mret;
                    state_d   = evt_mret ? S_STAT : S_W_EPC;
                end
            end
            S_W_EPC:   state_d = S_W_CAUSE;
            S_W_CAUSE: state_d = S_W_TVAL;
            S_W_TVAL:  state_d = S_STAT;
            S_STAT:    state_d = S_JUMP;
            S_JUMP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 32'h0;
            cause_q   <= 32'h0;
            tval_q    <= 32'h0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            tval_q    <= tval_d;
            is_mret_q <= is_mret_d;
        end
    end

    // Vectored mode applies to interrupts only; the offset add wraps at 32 bits.
    assign tvec_base = {csr_rdata[31:2], 2'b00};
    assign vec_mode  = VECTORED_EN && (csr_rdata[1:0] == 2'b01) && cause_q[31];

    always_comb begin
        hold_o      = accept;
        csr_we      = 1'b0;
        csr_addr    = 12'h0;
        csr_wdata   = 32'h0;
        jump_flag_o = 1'b0;
        jump_addr_o = 32'h0;
        case (state_q)
            S_W_EPC: begin
                hold_o    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = CSR_MEPC_A;
                csr_wdata = pc_q;
            end
            S_W_CAUSE: begin
                hold_o    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = CSR_MCAUSE_A;
                csr_wdata = cause_q;
            end
            S_W_TVAL: begin
                hold_o    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = CSR_MTVAL_A;
                csr_wdata = tval_q;
            end
            S_STAT: begin
                hold_o    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS_A;
                csr_wdata = is_mret_q ? mret_status(csr_rdata) : trap_status(csr_rdata);
            end
            S_JUMP: begin
                hold_o      = 1'b1;
                jump_flag_o = 1'b1;
                if (is_mret_q) begin
                    csr_addr    = CSR_MEPC_A;
                    jump_addr_o = csr_rdata;
                end else begin
                    csr_addr    = CSR_MTVEC_A;
                    jump_addr_o = vec_mode ? tvec_base + {cause_q[29:0], 2'b00} : tvec_base;
                end
            end
            default: ;
        endcase
    end

    assign csr_bus.trap_csr_we    = csr_we;
    assign csr_bus.trap_csr_addr  = csr_addr;
    assign csr_bus.trap_csr_wdata = csr_wdata;

endmodule
